// File: rtl/filter_buffer_manager_if.sv
// Filter-fetch bus: load stream, control pulses and the 4-bank read port.
// master = load unit / consumer side, slave = filter_buffer_manager.
interface filter_buffer_manager_if #(
  parameter int unsigned FILTER_DW     = 72,
  parameter int unsigned FILTER_BUF_AW = 8,
  parameter int unsigned W_LEN         = 9
);
  logic                     c_load_start;
  logic [W_LEN-1:0]         c_load_len;
  logic                     c_release;
  logic                     w_vld;
  logic [FILTER_DW-1:0]     w_data;
  logic                     w_rdy;
  logic                     fb_req;
  logic [FILTER_BUF_AW-1:0] fb_addr;
  logic                     fb_req_possible;
  logic [FILTER_DW-1:0]     fb_data0_out;
  logic [FILTER_DW-1:0]     fb_data1_out;
  logic [FILTER_DW-1:0]     fb_data2_out;
  logic [FILTER_DW-1:0]     fb_data3_out;
  logic                     o_load_done;
  logic                     o_busy;

  modport master (
    output c_load_start, c_load_len, c_release, w_vld, w_data, fb_req, fb_addr,
    input  w_rdy, fb_req_possible, fb_data0_out, fb_data1_out, fb_data2_out,
           fb_data3_out, o_load_done, o_busy
  );

  modport slave (
    input  c_load_start, c_load_len, c_release, w_vld, w_data, fb_req, fb_addr,
    output w_rdy, fb_req_possible, fb_data0_out, fb_data1_out, fb_data2_out,
           fb_data3_out, o_load_done, o_busy
  );
endinterface

// File: rtl/filter_buffer_manager.sv
// Filter tile buffer: streams a tile into Tout banks (address-major, filter-minor)
// and serves all banks in parallel with a one-cycle registered read.
module filter_buffer_manager #(
  parameter int unsigned FILTER_DW     = 72,
  parameter int unsigned FILTER_BUF_AW = 8,
  parameter int unsigned Tout          = 4,
  parameter int unsigned W_LEN         = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  filter_buffer_manager_if.slave  bus
);

  localparam int unsigned DEPTH  = 2 ** FILTER_BUF_AW;
  localparam int unsigned BSEL_W = $clog2(Tout);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [W_LEN-1:0]    len_q, len_d;
  logic [W_LEN-1:0]    addr_cnt_q, addr_cnt_d;
  logic [BSEL_W-1:0]   bank_sel_q, bank_sel_d;
  logic                w_rdy_q, o_busy_q, fb_req_possible_q, o_load_done_q;
  logic                load_start_c, wr_en_c, last_wr_c, empty_load_c, rd_en_c;
  logic [FILTER_DW-1:0] rd_q [Tout];

  // A new load is accepted from IDLE or READY; LOAD ignores it.
  assign load_start_c = bus.c_load_start && (state_q != S_LOAD);
  assign empty_load_c = load_start_c && (bus.c_load_len == '0);
  assign wr_en_c      = (state_q == S_LOAD) && bus.w_vld && w_rdy_q;
  assign last_wr_c    = wr_en_c && (bank_sel_q == BSEL_W'(Tout - 1))
                        && (addr_cnt_q == len_q - W_LEN'(1));
  assign rd_en_c      = (state_q == S_READY) && bus.fb_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      len_q             <= '0;
      addr_cnt_q        <= '0;
      bank_sel_q        <= '0;
      w_rdy_q           <= 1'b0;
      o_busy_q          <= 1'b0;
      fb_req_possible_q <= 1'b0;
      o_load_done_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      len_q             <= len_d;
      addr_cnt_q        <= addr_cnt_d;
      bank_sel_q        <= bank_sel_d;
      w_rdy_q           <= (state_d == S_LOAD);
      o_busy_q          <= (state_d == S_LOAD);
      fb_req_possible_q <= (state_d == S_READY);
      o_load_done_q     <= last_wr_c || empty_load_c;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_cnt_d = addr_cnt_q;
    bank_sel_d = bank_sel_q;
    case (state_q)
      S_IDLE: begin
        if (load_start_c) begin
          len_d      = bus.c_load_len;
          addr_cnt_d = '0;
          bank_sel_d = '0;
          state_d    = empty_load_c ? S_READY : S_LOAD;
        end
      end
      S_LOAD: begin
        if (wr_en_c) begin
          bank_sel_d = bank_sel_q + BSEL_W'(1);
          if (bank_sel_q == BSEL_W'(Tout - 1)) begin
            addr_cnt_d = addr_cnt_q + W_LEN'(1);
          end
          if (last_wr_c) begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        // Reload takes priority over release.
        if (load_start_c) begin
          len_d      = bus.c_load_len;
          addr_cnt_d = '0;
          bank_sel_d = '0;
          state_d    = empty_load_c ? S_READY : S_LOAD;
        end else if (bus.c_release) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One simple-dual-port RAM per bank; contents are not reset.
  for (genvar b = 0; b < Tout; b++) begin : g_bank
    logic [FILTER_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en_c && (bank_sel_q == BSEL_W'(b))) begin
        mem[FILTER_BUF_AW'(addr_cnt_q)] <= bus.w_data;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q[b] <= '0;
      end else if (rd_en_c) begin
        rd_q[b] <= mem[bus.fb_addr];
      end
    end
  end

  assign bus.w_rdy           = w_rdy_q;
  assign bus.o_busy          = o_busy_q;
  assign bus.fb_req_possible = fb_req_possible_q;
  assign bus.o_load_done     = o_load_done_q;
  assign bus.fb_data0_out    = rd_q[0];
  assign bus.fb_data1_out    = rd_q[1];
  assign bus.fb_data2_out    = rd_q[2];
  assign bus.fb_data3_out    = rd_q[3];

endmodule

// File: tb/tb_filter_buffer_manager.sv
// Self-checking bench for filter_buffer_manager: load/readback scoreboard plus
// stall, illegal-event and async-reset scenarios.
module tb_filter_buffer_manager;

  localparam int unsigned DW = 72;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 9;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  filter_buffer_manager_if #(.FILTER_DW(DW), .FILTER_BUF_AW(AW), .W_LEN(LW)) bus ();

  filter_buffer_manager #(
    .FILTER_DW(DW), .FILTER_BUF_AW(AW), .Tout(4), .W_LEN(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   model [4][256];
  logic [4*DW-1:0] exp_q [$];
  logic [4*DW-1:0] last_exp;
  logic            stall_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DW-1:0] got_data();
    return {bus.fb_data3_out, bus.fb_data2_out, bus.fb_data1_out, bus.fb_data0_out};
  endfunction

  function automatic logic [4*DW-1:0] model_row(input int unsigned a);
    return {model[3][a], model[2][a], model[1][a], model[0][a]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    last_exp = '0;
    checks++;
    if ({bus.w_rdy, bus.fb_req_possible, bus.o_load_done, bus.o_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got w_rdy/frp/done/busy=%b required 0000",
               {bus.w_rdy, bus.fb_req_possible, bus.o_load_done, bus.o_busy});
    end
    checks++;
    if (got_data() !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h required 0", got_data());
    end
  endtask

  // Loads len*4 words starting at value base. Optional side events exercise
  // same-cycle read-on-reload, release+start, and illegal events mid-LOAD.
  task automatic do_load(input int unsigned len, input logic [DW-1:0] base,
                         input bit stall, input bit mid_events,
                         input bit req_on_start, input bit rel_too,
                         input int unsigned abort_after);
    int unsigned k;
    int unsigned vi;
    logic        vld;
    logic [4*DW-1:0] e;
    bus.c_load_start = 1'b1;
    bus.c_load_len   = LW'(len);
    bus.c_release    = rel_too;
    if (req_on_start) begin
      bus.fb_req  = 1'b1;
      bus.fb_addr = '0;
      exp_q.push_back(model_row(0));
    end
    step();
    bus.c_load_start = 1'b0;
    bus.c_release    = 1'b0;
    bus.fb_req       = 1'b0;
    if (req_on_start) begin
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (got_data() !== e) begin
        errors++;
        $display("FAIL req_on_reload got=%h required=%h", got_data(), e);
      end
    end
    checks++;
    if ({bus.w_rdy, bus.o_busy, bus.fb_req_possible} !== 3'b110) begin
      errors++;
      $display("FAIL load_enter got w_rdy/busy/frp=%b required 110",
               {bus.w_rdy, bus.o_busy, bus.fb_req_possible});
    end
    k  = 0;
    vi = 0;
    while (k < len * 4) begin
      vld         = stall ? stall_pat[vi % 6] : 1'b1;
      vi++;
      bus.w_vld   = vld;
      bus.w_data  = base + DW'(k);
      if (mid_events && k == 1) begin
        bus.c_load_start = 1'b1;
        bus.c_load_len   = LW'(7);
        bus.fb_req       = 1'b1;
        bus.fb_addr      = '0;
        exp_q.push_back(last_exp);
      end
      step();
      bus.w_vld = 1'b0;
      if (mid_events && k == 1) begin
        bus.c_load_start = 1'b0;
        bus.fb_req       = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (got_data() !== e) begin
          errors++;
          $display("FAIL req_in_load got=%h required=%h", got_data(), e);
        end
      end
      if (vld) begin
        model[k % 4][k / 4] = base + DW'(k);
        k++;
        if (abort_after != 0 && k == abort_after) return;
      end
      if (k < len * 4) begin
        checks++;
        if (bus.w_rdy !== 1'b1 || bus.o_load_done !== 1'b0) begin
          errors++;
          $display("FAIL load_wrdy word=%0d got w_rdy=%b done=%b required 1 0",
                   k, bus.w_rdy, bus.o_load_done);
        end
      end
    end
    checks++;
    if ({bus.o_load_done, bus.w_rdy, bus.fb_req_possible, bus.o_busy} !== 4'b1010) begin
      errors++;
      $display("FAIL load_done got done/w_rdy/frp/busy=%b required 1010",
               {bus.o_load_done, bus.w_rdy, bus.fb_req_possible, bus.o_busy});
    end
    step();
    checks++;
    if (bus.o_load_done !== 1'b0 || bus.fb_req_possible !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got done=%b frp=%b required 0 1",
               bus.o_load_done, bus.fb_req_possible);
    end
  endtask

  // Back-to-back reads from a_start, then one idle cycle to check hold.
  task automatic do_reads(input int unsigned n, input int unsigned a_start);
    logic [4*DW-1:0] e;
    for (int unsigned i = 0; i < n; i++) begin
      bus.fb_req  = 1'b1;
      bus.fb_addr = AW'(a_start + i);
      exp_q.push_back(model_row(a_start + i));
      step();
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (got_data() !== e) begin
        errors++;
        $display("FAIL read addr=%0d got=%h required=%h", a_start + i, got_data(), e);
      end
    end
    bus.fb_req = 1'b0;
    step();
    checks++;
    if (got_data() !== last_exp) begin
      errors++;
      $display("FAIL read_hold got=%h required=%h", got_data(), last_exp);
    end
  endtask

  task automatic test_full_load();
    do_load(2, 72'h1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_read_latency();
    logic [4*DW-1:0] e0;
    e0 = {72'h4, 72'h3, 72'h2, 72'h1};
    checks++;
    if (model_row(0) !== e0) begin
      errors++;
      $display("FAIL model_row0 got=%h required=%h", model_row(0), e0);
    end
    do_reads(2, 0);
    checks++;
    if (got_data() !== {72'h8, 72'h7, 72'h6, 72'h5}) begin
      errors++;
      $display("FAIL read_addr1_const got=%h required=%h", got_data(),
               {72'h8, 72'h7, 72'h6, 72'h5});
    end
  endtask

  task automatic test_stall();
    do_load(1, 72'h11, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    do_reads(1, 0);
  endtask

  task automatic test_illegal();
    logic [4*DW-1:0] e;
    // Reload from READY with a same-cycle read, plus fb_req / c_load_start mid-LOAD.
    do_load(1, 72'h21, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    do_reads(1, 0);
    // Zero-length load: straight to READY, no writes.
    bus.c_load_start = 1'b1;
    bus.c_load_len   = '0;
    step();
    bus.c_load_start = 1'b0;
    checks++;
    if ({bus.o_load_done, bus.fb_req_possible, bus.w_rdy, bus.o_busy} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_len got done/frp/w_rdy/busy=%b required 1100",
               {bus.o_load_done, bus.fb_req_possible, bus.w_rdy, bus.o_busy});
    end
    step();
    checks++;
    if (bus.o_load_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse got done=%b required 0", bus.o_load_done);
    end
    do_reads(2, 0);
    // Release, then a read in IDLE is ignored.
    bus.c_release = 1'b1;
    step();
    bus.c_release = 1'b0;
    checks++;
    if (bus.fb_req_possible !== 1'b0) begin
      errors++;
      $display("FAIL release got frp=%b required 0", bus.fb_req_possible);
    end
    bus.fb_req  = 1'b1;
    bus.fb_addr = AW'(1);
    exp_q.push_back(last_exp);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (got_data() !== e) begin
      errors++;
      $display("FAIL req_in_idle got=%h required=%h", got_data(), e);
    end
    do_load(1, 72'h31, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_load(1, 72'h41, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    do_reads(1, 0);
  endtask

  task automatic test_reset_mid_load();
    do_load(2, 72'h51, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    last_exp = '0;
    checks++;
    if ({bus.w_rdy, bus.fb_req_possible, bus.o_busy, bus.o_load_done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort got w_rdy/frp/busy/done=%b required 0000",
               {bus.w_rdy, bus.fb_req_possible, bus.o_busy, bus.o_load_done});
    end
    checks++;
    if (got_data() !== '0) begin
      errors++;
      $display("FAIL abort_data got=%h required 0", got_data());
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    do_load(2, 72'h61, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_reads(2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.c_load_start = 1'b0;
    bus.c_load_len   = '0;
    bus.c_release    = 1'b0;
    bus.w_vld        = 1'b0;
    bus.w_data       = '0;
    bus.fb_req       = 1'b0;
    bus.fb_addr      = '0;
    last_exp         = '0;
    test_reset();
    test_full_load();
    test_read_latency();
    test_stall();
    test_illegal();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_buffer_manager.md
Name: filter_buffer_manager

Overview:
- Responder side of the PE filter-fetch interface.
- Accepts a filter tile from the load path as a valid/ready stream and stores it in Tout parallel banks, one bank per output-channel filter.
- Raises fb_req_possible once the tile is complete.
- Answers each fb_req/fb_addr with the four bank words exactly one cycle later, which is the consumer's FB_DELAY of 1.
- Sits between the DMA/load unit and pe_engine.

Parameters:
- FILTER_DW, 72, filter word width (K*K taps x 8 bit).
- FILTER_BUF_AW, 8, bank address width; depth is 2**FILTER_BUF_AW.
- Tout, 4, number of banks and read outputs; fixed at 4.
- W_LEN, 9, width of the load-length field in words per bank.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- c_load_start  in  1  pulse: begin loading a new tile.
- c_load_len  in  W_LEN  words per bank (q_channel*Tin); sampled on c_load_start.
- c_release  in  1  pulse: tile consumed, return to IDLE.
- w_vld  in  1  write stream valid.
- w_data  in  FILTER_DW  write word.
- w_rdy  out  1  write stream ready.
- fb_req  in  1  read request from pe_engine.
- fb_addr  in  FILTER_BUF_AW  read address.
- fb_req_possible  out  1  tile resident, reads permitted.
- fb_data0_out .. fb_data3_out  out  FILTER_DW each  bank 0..3 read data.
- o_load_done  out  1  one-cycle pulse when the last word is written.
- o_busy  out  1  high in LOAD.

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters and outputs 0, including fb_data*, w_rdy, fb_req_possible, o_load_done and o_busy. Memory contents are not reset.
- FSM states are IDLE, LOAD and READY.
- IDLE -> LOAD on c_load_start with c_load_len != 0. This latches len, clears bank_sel=0 and addr_cnt=0.
- IDLE -> READY on c_load_start with c_load_len == 0. o_load_done pulses the next cycle.
- LOAD:
  - w_rdy=1 and o_busy=1.
  - A write occurs on w_vld&w_rdy: bank[bank_sel][addr_cnt] <= w_data.
  - Write ordering: bank_sel increments 0..3; on wrap it returns to 0 and addr_cnt increments. The stream order is therefore address-major, filter-minor.
  - LOAD -> READY on the write with bank_sel==3 && addr_cnt==len-1.
  - w_rdy drops in the cycle after that final write.
  - o_load_done=1 for exactly the first READY cycle.
- READY:
  - fb_req_possible=1.
  - On fb_req, register mem[b][fb_addr] into fb_data{b}_out for all four banks. Data is valid in the cycle after the request, with a latency of exactly 1.
  - Back-to-back requests give one word set per cycle.
  - Without fb_req, the fb_data outputs hold their last value.
  - READY -> IDLE on c_release. fb_req_possible drops the next cycle.
  - READY -> LOAD on c_load_start, which reloads. A fb_req in that same cycle is still served from the old contents.
- fb_req outside READY is ignored; the fb_data outputs hold.
- c_load_start in LOAD is ignored and the load continues.
- c_release outside READY is ignored.
- If c_release and c_load_start are asserted in the same cycle in READY, c_load_start wins.
- fb_addr >= len returns stale memory contents; this is not flagged. Consumer responsibility.
- w_vld outside LOAD: no write, and w_rdy=0.
- A stalled stream (w_vld=0) leaves the counters unchanged; there is no timeout.
- rst mid-LOAD aborts to IDLE. Partial contents are treated as invalid.
- Memory is inferred as Tout simple-dual-port RAMs, one write port and one registered read port each.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> all outputs 0, state IDLE, w_rdy=0.
- Full load: c_load_start with c_load_len=2, stream 8 words 0x1..0x8 with w_vld continuous. Required response:
  - w_rdy high for 8 handshakes;
  - o_load_done pulses once in the cycle after the 8th handshake;
  - fb_req_possible=1 thereafter.
- Read latency: after the load above, fb_req with addr=0 at cycle t and addr=1 at t+1. Required response:
  - at t+1, fb_data0..3 = 0x1,0x2,0x3,0x4;
  - at t+2, fb_data0..3 = 0x5,0x6,0x7,0x8;
  - values held at t+3 with fb_req=0.
- Stalled stream: with c_load_len=1, toggle w_vld 1,0,0,1,1,1 -> exactly 4 writes, in order to banks 0..3 at addr 0, then READY.
- Illegal/boundary events:
  - fb_req during LOAD -> fb_data unchanged;
  - c_load_start mid-LOAD -> ignored, word count unchanged;
  - c_load_start with c_load_len=0 -> READY with o_load_done pulse and no writes;
  - c_release with c_load_start together in READY -> LOAD.
- Async reset mid-LOAD: assert rst after 3 of 8 words -> immediate IDLE, w_rdy=0, fb_req_possible=0. A following full load then reads back correctly.
